// File: rtl/bus_6502_responder.sv
// Bus-side partner of the netlist-level 6502 core.
// Derives the 6502 clock (phi) and the core reset from clk, samples each CPU bus cycle
// at a settle point during phi high, and issues it as one req/ack transaction. phi is
// held high until the slave acknowledges, so slow slaves insert wait states.
//
// Ports:
//   clk, rst        FPGA clock, synchronous active-high reset
//   phi             6502 clock (0 = PH1, 1 = PH2)
//   cpu_res_n       active-low core reset, released after RES_CYCLES phi cycles
//   cpu_ab/dbo/rw   core address, write data, read/write (1 = read)
//   cpu_dbi         read data returned to the core
//   mem_req         request level, one per phi cycle
//   mem_addr/we/wdata  transaction fields, stable while mem_req is high
//   mem_ack         one-cycle completion pulse
//   mem_rdata       read data, valid with mem_ack
module bus_6502_responder #(
  parameter int unsigned HALF       = 16,
  parameter int unsigned SETTLE     = 12,
  parameter int unsigned RES_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        phi,
  output logic        cpu_res_n,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_dbo,
  input  logic        cpu_rw,
  output logic [7:0]  cpu_dbi,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned CntW = (HALF > 2) ? $clog2(HALF) : 1;
  localparam int unsigned ResW = (RES_CYCLES > 1) ? $clog2(RES_CYCLES + 1) : 1;

  localparam logic [CntW-1:0] CntLast   = CntW'(HALF - 1);
  localparam logic [CntW-1:0] CntSettle = CntW'(SETTLE);
  localparam logic [ResW-1:0] ResFinal  = ResW'(RES_CYCLES - 1);

  typedef enum logic [0:0] {StPh1, StPh2} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic [ResW-1:0] res_cnt_q;

  logic ack_now;
  logic finished;

  // Acks are only meaningful while a request is outstanding.
  assign ack_now  = mem_req & mem_ack;
  // Counting the ack cycle itself lets phi fall on the edge that closes the transaction.
  assign finished = done_q | ack_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StPh1;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      res_cnt_q <= '0;
      phi       <= 1'b0;
      cpu_res_n <= 1'b0;
      cpu_dbi   <= 8'h00;
      mem_req   <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
    end else begin
      unique case (state_q)
        StPh1: begin
          if (cnt_q == CntLast) begin
            state_q <= StPh2;
            phi     <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StPh2: begin
          // Sample the bus once per phi cycle, after the core outputs have settled.
          if ((cnt_q == CntSettle) && !mem_req && !done_q) begin
            mem_req   <= 1'b1;
            mem_addr  <= cpu_ab;
            mem_we    <= ~cpu_rw;
            mem_wdata <= cpu_dbo;
          end

          if (ack_now) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              cpu_dbi <= mem_rdata;
            end
          end

          // cnt saturates at CntLast, so equality here means "at least HALF-1".
          if ((cnt_q == CntLast) && finished) begin
            state_q <= StPh1;
            phi     <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            if (!cpu_res_n) begin
              res_cnt_q <= res_cnt_q + 1'b1;
              if (res_cnt_q == ResFinal) begin
                cpu_res_n <= 1'b1;
              end
            end
          end else begin
            if (ack_now) begin
              done_q <= 1'b1;
            end
            if (cnt_q != CntLast) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= StPh1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_6502_responder.sv
// Bench for bus_6502_responder with HALF = 4, SETTLE = 2, RES_CYCLES = 2.
// A reference model tracks the expected phi timing (low = HALF, high =
// max(HALF, SETTLE + 2 + L)), the transaction fields, the last read data seen by the
// core and the number of completed phi cycles that gate cpu_res_n.
module tb_bus_6502_responder;

  localparam int HALF   = 4;
  localparam int SETTLE = 2;
  localparam int RES    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        phi;
  logic        cpu_res_n;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_dbo;
  logic        cpu_rw;
  logic [7:0]  cpu_dbi;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [7:0] exp_dbi;
  int         falls;

  bus_6502_responder #(
    .HALF      (HALF),
    .SETTLE    (SETTLE),
    .RES_CYCLES(RES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .phi      (phi),
    .cpu_res_n(cpu_res_n),
    .cpu_ab   (cpu_ab),
    .cpu_dbo  (cpu_dbo),
    .cpu_rw   (cpu_rw),
    .cpu_dbi  (cpu_dbi),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one phi cycle starting on its first PH1 sample and returns on the first PH1
  // sample of the next one. The slave acks after lat request cycles.
  task automatic run_phi_cycle(input logic [15:0] ab, input logic rw, input logic [7:0] dbo,
                               input int lat, input logic [7:0] rdata, input bit spur,
                               output int low, output int high);
    int         reqc;
    int         guard;
    int         exp_high;
    bit         seen_high;
    bit         read_pend;
    logic [7:0] pend_val;
    cpu_ab    = ab;
    cpu_rw    = rw;
    cpu_dbo   = dbo;
    low       = 0;
    high      = 0;
    reqc      = 0;
    guard     = 0;
    seen_high = 1'b0;
    read_pend = 1'b0;
    pend_val  = 8'h00;
    while (guard < 200) begin
      mem_ack = 1'b0;
      if (read_pend) begin
        exp_dbi   = pend_val;
        read_pend = 1'b0;
      end
      if (phi === 1'b1) begin
        seen_high = 1'b1;
      end else if (seen_high) begin
        break;
      end
      n_cmp++;
      if (cpu_dbi !== exp_dbi) begin
        n_bad++;
        $display("FAIL cpu_dbi: got %h want %h (t=%0t)", cpu_dbi, exp_dbi, $time);
      end
      n_cmp++;
      if (cpu_res_n !== (falls >= RES)) begin
        n_bad++;
        $display("FAIL cpu_res_n: got %b want %b after %0d phi cycles", cpu_res_n,
                 (falls >= RES), falls);
      end
      if (phi === 1'b1) high++;
      else low++;
      if (mem_req === 1'b1) begin
        reqc++;
        n_cmp++;
        if (mem_addr !== ab || mem_we !== !rw || mem_wdata !== dbo) begin
          n_bad++;
          $display("FAIL txn fields: got a=%h we=%b d=%h want a=%h we=%b d=%h",
                   mem_addr, mem_we, mem_wdata, ab, !rw, dbo);
        end
        if (reqc == lat + 1) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
          if (rw) begin
            read_pend = 1'b1;
            pend_val  = rdata;
          end
        end else begin
          mem_rdata = 8'($urandom);
        end
        // The core may change its outputs once the request is latched.
        cpu_ab  = 16'($urandom);
        cpu_dbo = 8'($urandom);
        cpu_rw  = 1'($urandom);
      end else if (spur && ((phi === 1'b0 && low == 2) || (phi === 1'b1 && reqc > lat))) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'($urandom);
      end
      step();
      guard++;
    end
    mem_ack = 1'b0;
    n_cmp++;
    if (guard >= 200) begin
      n_bad++;
      $display("FAIL phi cycle timeout: got %0d clk want < 200", guard);
    end
    exp_high = (SETTLE + 2 + lat > HALF) ? SETTLE + 2 + lat : HALF;
    n_cmp++;
    if (low != HALF) begin
      n_bad++;
      $display("FAIL phi low: got %0d want %0d", low, HALF);
    end
    n_cmp++;
    if (high != exp_high) begin
      n_bad++;
      $display("FAIL phi high: got %0d want %0d (L=%0d)", high, exp_high, lat);
    end
    n_cmp++;
    if (reqc != lat + 1) begin
      n_bad++;
      $display("FAIL mem_req length: got %0d want %0d", reqc, lat + 1);
    end
    falls++;
  endtask

  task automatic test_reset();
    int low;
    int high;
    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    cpu_ab    = 16'h0000;
    cpu_dbo   = 8'h00;
    cpu_rw    = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({phi, cpu_res_n, mem_req, mem_we} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset ctrl: got phi/res_n/req/we=%b want 0000",
               {phi, cpu_res_n, mem_req, mem_we});
    end
    n_cmp++;
    if (cpu_dbi !== 8'h00) begin
      n_bad++;
      $display("FAIL reset cpu_dbi: got %h want 00", cpu_dbi);
    end
    n_cmp++;
    if (mem_addr !== 16'h0000 || mem_wdata !== 8'h00) begin
      n_bad++;
      $display("FAIL reset mem fields: got a=%h d=%h want 0000/00", mem_addr, mem_wdata);
    end
    rst     = 1'b0;
    exp_dbi = 8'h00;
    falls   = 0;
    run_phi_cycle(16'hFFFC, 1'b1, 8'h00, 0, 8'h11, 1'b0, low, high);
    n_cmp++;
    if (low + high != 2 * HALF) begin
      n_bad++;
      $display("FAIL first falling phi: got %0d clk want %0d", low + high, 2 * HALF);
    end
    for (int i = 0; i < 3; i++) begin
      run_phi_cycle(16'($urandom), 1'b1, 8'($urandom), 0, 8'($urandom), 1'b0, low, high);
    end
  endtask

  task automatic test_read();
    int low;
    int high;
    run_phi_cycle(16'hFFFC, 1'b1, 8'h00, 0, 8'hA9, 1'b0, low, high);
    n_cmp++;
    if (cpu_dbi !== 8'hA9) begin
      n_bad++;
      $display("FAIL read data: got %h want a9", cpu_dbi);
    end
  endtask

  task automatic test_write();
    int low;
    int high;
    run_phi_cycle(16'h0200, 1'b0, 8'h5A, 0, 8'h33, 1'b0, low, high);
    n_cmp++;
    if (cpu_dbi !== 8'hA9) begin
      n_bad++;
      $display("FAIL write keeps cpu_dbi: got %h want a9", cpu_dbi);
    end
  endtask

  task automatic test_wait_states();
    int low;
    int high;
    run_phi_cycle(16'h8000, 1'b1, 8'h00, 10, 8'hC3, 1'b0, low, high);
    n_cmp++;
    if (high != 14) begin
      n_bad++;
      $display("FAIL wait-state phi high: got %0d want 14", high);
    end
    run_phi_cycle(16'h8001, 1'b0, 8'h77, 0, 8'h00, 1'b0, low, high);
  endtask

  task automatic test_spurious_ack();
    int low;
    int high;
    run_phi_cycle(16'h1234, 1'b0, 8'h42, 1, 8'hEE, 1'b1, low, high);
    n_cmp++;
    if (low + high != 9 || cpu_dbi !== 8'hC3) begin
      n_bad++;
      $display("FAIL spurious ack: got period %0d dbi %h want 9 c3", low + high, cpu_dbi);
    end
    run_phi_cycle(16'h1235, 1'b1, 8'h00, 0, 8'h5E, 1'b1, low, high);
  endtask

  task automatic test_random();
    int low;
    int high;
    for (int i = 0; i < 40; i++) begin
      run_phi_cycle(16'($urandom), 1'($urandom), 8'($urandom), int'($urandom_range(0, 12)),
                    8'($urandom), 1'($urandom), low, high);
    end
  endtask

  task automatic test_mid_reset();
    int low;
    int high;
    int guard;
    // Make sure reset has visible work to undo.
    run_phi_cycle(16'hBEEF, 1'b1, 8'h00, 0, 8'hD7, 1'b0, low, high);
    cpu_ab = 16'h4321;
    cpu_rw = 1'b1;
    guard  = 0;
    while (mem_req !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL mid-reset request: got %b want 1", mem_req);
    end
    step();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({mem_req, phi, cpu_res_n} !== 3'b000 || cpu_dbi !== 8'h00) begin
      n_bad++;
      $display("FAIL mid-reset: got req/phi/res_n=%b dbi=%h want 000 00",
               {mem_req, phi, cpu_res_n}, cpu_dbi);
    end
    rst     = 1'b0;
    exp_dbi = 8'h00;
    falls   = 0;
    for (int i = 0; i < 4; i++) begin
      run_phi_cycle(16'($urandom), 1'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                    8'($urandom), 1'b0, low, high);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wait_states();
    test_spurious_ack();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
